// File: rtl/match_scheduler_if.sv
// Bus bundle for match_scheduler: run control, sample memory port, matcher port and results.
// The scheduler uses the master modport; the environment driving it uses slave.
interface match_scheduler_if;
    logic          i_start;
    logic [9:0]    i_num_samples;
    logic [1279:0] i_base_des;
    logic [9:0]    o_mem_addr;
    logic          o_mem_rd;
    logic [1279:0] i_mem_data;
    logic          i_mem_valid;
    logic [1279:0] o_base_des;
    logic [1279:0] o_sample_des;
    logic          o_match_en;
    logic [16:0]   i_dist;
    logic          i_dist_valid;
    logic          o_busy;
    logic          o_done;
    logic [9:0]    o_best_idx;
    logic [16:0]   o_best_dist;
    logic [16:0]   o_second_dist;
    logic          o_match_ok;

    modport master (
        input  i_start, i_num_samples, i_base_des, i_mem_data, i_mem_valid, i_dist, i_dist_valid,
        output o_mem_addr, o_mem_rd, o_base_des, o_sample_des, o_match_en,
               o_busy, o_done, o_best_idx, o_best_dist, o_second_dist, o_match_ok
    );

    modport slave (
        output i_start, i_num_samples, i_base_des, i_mem_data, i_mem_valid, i_dist, i_dist_valid,
        input  o_mem_addr, o_mem_rd, o_base_des, o_sample_des, o_match_en,
               o_busy, o_done, o_best_idx, o_best_dist, o_second_dist, o_match_ok
    );
endinterface

// File: rtl/match_scheduler.sv
// Walks sample descriptors through an external matcher and keeps the best/second-best distance.
// Define MATCH_RATIO_TEST_EN to enable second-distance tracking and the ratio test.
module match_scheduler #(
    parameter int RATIO_NUM = 4,
    parameter int RATIO_DEN = 5,
    parameter int PIPE_LAT  = 8
) (
    input  logic               iclk,
    input  logic               ireset,
    match_scheduler_if.master  bus
);
    localparam int          LW   = $clog2(PIPE_LAT + 1);
    localparam logic [16:0] MAXD = 17'h1FFFF;

    typedef enum logic [2:0] {IDLE, FETCH, WAIT_MEM, COMPUTE, UPDATE, DONE} state_t;

    state_t         r_state, w_next;
    logic [9:0]     r_index, r_num, r_best_idx;
    logic [LW-1:0]  r_lat;
    logic [16:0]    r_best, r_dist;
    logic [1279:0]  r_base, r_sample;
    logic           r_done, r_match_ok;
    logic           w_accept, w_last, w_ratio_ok;

    // Matcher results are only trusted once the pipeline has had PIPE_LAT cycles on this sample
    assign w_accept = (r_state == COMPUTE) && bus.i_dist_valid && (r_lat >= LW'(PIPE_LAT));
    assign w_last   = (r_index == r_num - 10'd1);

    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset) r_state <= IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     if (bus.i_start) w_next = (bus.i_num_samples == 10'd0) ? DONE : FETCH;
            FETCH:    w_next = WAIT_MEM;
            WAIT_MEM: if (bus.i_mem_valid) w_next = COMPUTE;
            COMPUTE:  if (w_accept) w_next = UPDATE;
            UPDATE:   w_next = w_last ? DONE : FETCH;
            DONE:     w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset) begin
            r_index    <= '0;
            r_num      <= '0;
            r_best_idx <= '0;
            r_lat      <= '0;
            r_best     <= MAXD;
            r_dist     <= '0;
            r_base     <= '0;
            r_sample   <= '0;
            r_done     <= 1'b0;
            r_match_ok <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (bus.i_start) begin
                    r_base     <= bus.i_base_des;
                    r_num      <= bus.i_num_samples;
                    r_index    <= '0;
                    r_best_idx <= '0;
                    r_best     <= MAXD;
                    r_match_ok <= 1'b0;
                end
                WAIT_MEM: if (bus.i_mem_valid) begin
                    r_sample <= bus.i_mem_data;
                    r_lat    <= '0;
                end
                COMPUTE: begin
                    if (r_lat < LW'(PIPE_LAT)) r_lat <= r_lat + LW'(1);
                    if (w_accept) r_dist <= bus.i_dist;
                end
                UPDATE: begin
                    if (r_dist < r_best) begin
                        r_best     <= r_dist;
                        r_best_idx <= r_index;
                    end
                    if (!w_last) r_index <= r_index + 10'd1;
                end
                DONE: begin
                    r_done     <= 1'b1;
                    r_match_ok <= w_ratio_ok;
                end
                default: ;
            endcase
        end
    end

`ifdef MATCH_RATIO_TEST_EN
    logic [16:0] r_second;
    logic [19:0] w_best_x_den, w_second_x_num;

    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset) begin
            r_second <= MAXD;
        end else if (r_state == IDLE && bus.i_start) begin
            r_second <= MAXD;
        end else if (r_state == UPDATE) begin
            // A tie with best demotes the old best into second, so equal distances fail the ratio test
            if (r_dist < r_best)        r_second <= r_best;
            else if (r_dist < r_second) r_second <= r_dist;
        end
    end

    // 17-bit distance times a small constant fits in 20 bits without wrap
    assign w_best_x_den   = {3'b000, r_best}   * 20'(RATIO_DEN);
    assign w_second_x_num = {3'b000, r_second} * 20'(RATIO_NUM);
    assign w_ratio_ok     = (w_best_x_den < w_second_x_num) && (r_num != 10'd0);
    assign bus.o_second_dist = r_second;
`else
    localparam int unused_ratio_params = RATIO_NUM + RATIO_DEN;
    assign w_ratio_ok        = (r_num != 10'd0);
    assign bus.o_second_dist = MAXD;
`endif

    assign bus.o_mem_addr   = r_index;
    assign bus.o_mem_rd     = (r_state == FETCH);
    assign bus.o_match_en   = (r_state == COMPUTE);
    assign bus.o_busy       = (r_state != IDLE);
    assign bus.o_done       = r_done;
    assign bus.o_base_des   = r_base;
    assign bus.o_sample_des = r_sample;
    assign bus.o_best_idx   = r_best_idx;
    assign bus.o_best_dist  = r_best;
    assign bus.o_match_ok   = r_match_ok;
endmodule
